// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard controller for the 5-stage forwarding CPU. It sits beside decode.
//   Each cycle it compares the ID source registers with the EX and MEM
//   destinations. From that it drives:
//     - the operand forwarding selects,
//     - the PC / IF-ID write-inhibit (wpcir),
//     - the EX bubble,
//     - the IF flush.
//   A three-state FSM (RUN / STALL / FLUSH) stretches load-use stalls and
//   taken-branch flushes over several cycles.
//
// Parameters
//   LOAD_STALL_CYC  cycles wpcir is held per load-use hazard (1..3)
//   FLUSH_CYC       cycles flush_if is held after a taken branch (1..2)
//   CNT_W           width of the performance counters
//
// Ports
//   clk, rst             clock (rising edge); asynchronous active-high reset
//   id_rs/id_rt          source register fields of the ID instruction
//   id_use_rs/id_use_rt  ID instruction really reads rs / rt
//   ex_destR/ex_wreg/ex_m2reg     EX destination, writes-regfile, is-load
//   mem_destR/mem_wreg/mem_m2reg  MEM destination, writes-regfile, is-load
//   id_branch            branch in ID resolves taken this cycle
//   fwda/fwdb            00 regfile, 01 EX alu, 10 MEM alu, 11 MEM load data
//   wpcir                hold PC and IF/ID
//   bubble_ex            ID/EX latches a NOP
//   flush_if             IF/ID latches a zero instruction
//   stall_cnt/flush_cnt  performance counters (saturating)
//
// Build option
//   HAZARD_PERF_CNT_EN   When defined, the stall and flush counters are
//                        implemented. Otherwise both outputs are tied to 0.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int LOAD_STALL_CYC = 1,
    parameter int FLUSH_CYC      = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       ex_destR,
    input  logic             ex_wreg,
    input  logic             ex_m2reg,
    input  logic [4:0]       mem_destR,
    input  logic             mem_wreg,
    input  logic             mem_m2reg,
    input  logic             id_branch,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             wpcir,
    output logic             bubble_ex,
    output logic             flush_if,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // The first hazard cycle is spent in RUN. So the extra states only
    // cover the remaining N-1 cycles.
    localparam logic [1:0] STALL_RELOAD = 2'(LOAD_STALL_CYC - 1);
    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYC - 1);

    state_t     state_reg, state_next;
    logic [1:0] cnt_reg, cnt_next;
    logic       lu;
    logic [1:0] fwda_next, fwdb_next;

    // Forwarding select for one source operand.
    //   - EX wins over MEM.
    //   - A load in EX cannot forward its data yet, so it falls through to
    //     the MEM check. The stall logic covers that case.
    function automatic logic [1:0] fwd_sel(input logic src_used, input logic [4:0] src,
                                           input logic [4:0] e_dest, input logic e_wreg,
                                           input logic e_m2reg, input logic [4:0] m_dest,
                                           input logic m_wreg, input logic m_m2reg);
        if (!src_used || src == 5'd0)
            return 2'b00;
        if (e_wreg && !e_m2reg && e_dest == src)
            return 2'b01;
        if (m_wreg && m_dest == src)
            return m_m2reg ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    assign fwda_next = fwd_sel(id_use_rs, id_rs, ex_destR, ex_wreg, ex_m2reg,
                               mem_destR, mem_wreg, mem_m2reg);
    assign fwdb_next = fwd_sel(id_use_rt, id_rt, ex_destR, ex_wreg, ex_m2reg,
                               mem_destR, mem_wreg, mem_m2reg);

    // Load-use hazard: the EX load's data only exists after MEM.
    assign lu = ex_wreg && ex_m2reg && (ex_destR != 5'd0) &&
                ((id_use_rs && id_rs == ex_destR) || (id_use_rt && id_rt == ex_destR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
            cnt_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        wpcir      = 1'b0;
        bubble_ex  = 1'b0;
        flush_if   = 1'b0;
        fwda       = fwda_next;
        fwdb       = fwdb_next;

        case (state_reg)
            RUN: begin
                // A load-use hazard takes precedence over a branch. The
                // branch is re-evaluated once the stall has finished.
                if (lu) begin
                    wpcir     = 1'b1;
                    bubble_ex = 1'b1;
                    if (LOAD_STALL_CYC > 1) begin
                        state_next = STALL;
                        cnt_next   = STALL_RELOAD;
                    end
                end else if (id_branch) begin
                    flush_if = 1'b1;
                    if (FLUSH_CYC > 1) begin
                        state_next = FLUSH;
                        cnt_next   = FLUSH_RELOAD;
                    end
                end
            end
            STALL: begin
                wpcir     = 1'b1;
                bubble_ex = 1'b1;
                cnt_next  = cnt_reg - 2'd1;
                if (cnt_reg == 2'd1)
                    state_next = RUN;
            end
            FLUSH: begin
                // A load-use hazard seen here is picked up again in RUN.
                flush_if = 1'b1;
                cnt_next = cnt_reg - 2'd1;
                if (cnt_reg == 2'd1)
                    state_next = RUN;
            end
            default: begin
                state_next = RUN;
                cnt_next   = 2'd0;
            end
        endcase

        // Keep every control output quiet while reset is held, whatever
        // the pipeline inputs show.
        if (rst) begin
            wpcir     = 1'b0;
            bubble_ex = 1'b0;
            flush_if  = 1'b0;
            fwda      = 2'b00;
            fwdb      = 2'b00;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

    // Both counters stop at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (wpcir && stall_cnt_reg != '1)
                stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
            if (flush_if && flush_cnt_reg != '1)
                flush_cnt_reg <= flush_cnt_reg + CNT_ONE;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed bench for hazard_ctrl. Two instances share the same stimulus:
//     u_a : LOAD_STALL_CYC = 2, FLUSH_CYC = 2
//     u_b : LOAD_STALL_CYC = 3, FLUSH_CYC = 1
//   Inputs change 1 ns after the rising edge. Outputs are checked on the
//   falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_destR, mem_destR;
    logic        id_use_rs, id_use_rt, ex_wreg, ex_m2reg, mem_wreg, mem_m2reg, id_branch;

    logic [1:0]  fwda_a, fwdb_a, fwda_b, fwdb_b;
    logic        wpcir_a, bubble_a, flush_a, wpcir_b, bubble_b, flush_b;
    logic [15:0] stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_STALL_CYC(2), .FLUSH_CYC(2), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_destR(ex_destR), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
        .mem_destR(mem_destR), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
        .id_branch(id_branch),
        .fwda(fwda_a), .fwdb(fwdb_a), .wpcir(wpcir_a), .bubble_ex(bubble_a),
        .flush_if(flush_a), .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
    );

    hazard_ctrl #(.LOAD_STALL_CYC(3), .FLUSH_CYC(1), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_destR(ex_destR), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
        .mem_destR(mem_destR), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
        .id_branch(id_branch),
        .fwda(fwda_b), .fwdb(fwdb_b), .wpcir(wpcir_b), .bubble_ex(bubble_b),
        .flush_if(flush_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        ex_destR = 5'd0; ex_wreg = 1'b0; ex_m2reg = 1'b0;
        mem_destR = 5'd0; mem_wreg = 1'b0; mem_m2reg = 1'b0;
        id_branch = 1'b0;
    endtask

    // Load in EX writing r8, with the ID instruction reading r8 through rs.
    task automatic set_load_use();
        ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_destR = 5'd8;
        id_rs = 5'd8; id_use_rs = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        next_cycle();
        rst = 1'b0;
    endtask

    function automatic logic [15:0] pc(input logic [15:0] v);
        return PERF ? v : 16'h0;
    endfunction

    initial begin
        rst = 1'b1;
        clear_inputs();

        // ---- reset state
        @(negedge clk);
        check("rst_fwda",  32'(fwda_a), 32'd0);
        check("rst_fwdb",  32'(fwdb_a), 32'd0);
        check("rst_wpcir", 32'(wpcir_a), 32'd0);
        check("rst_bubble", 32'(bubble_a), 32'd0);
        check("rst_flush", 32'(flush_a), 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt_a), 32'd0);
        check("rst_flush_cnt", 32'(flush_cnt_b), 32'd0);
        next_cycle();
        rst = 1'b0;
        $display("step reset: reset state checked");

        // ---- 1: async reset in the middle of a 3-cycle stall
        set_load_use();
        @(negedge clk);
        check("t1_b_wpcir_c0", 32'(wpcir_b), 32'd1);
        next_cycle();
        @(negedge clk);
        check("t1_b_wpcir_stall", 32'(wpcir_b), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("t1_b_wpcir_in_rst",  32'(wpcir_b), 32'd0);
        check("t1_b_bubble_in_rst", 32'(bubble_b), 32'd0);
        clear_inputs();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("t1_b_wpcir_after", 32'(wpcir_b), 32'd0);
        check("t1_b_stall_cnt",   32'(stall_cnt_b), 32'd0);
        check("t1_a_stall_cnt",   32'(stall_cnt_a), 32'd0);
        $display("step 1: reset mid-stall checked");

        // ---- 2: EX ALU forwarding and MEM ALU forwarding
        next_cycle();
        ex_wreg = 1'b1; ex_m2reg = 1'b0; ex_destR = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
        @(negedge clk);
        check("t2_fwda_ex",  32'(fwda_a), 32'h1);
        check("t2_fwdb",     32'(fwdb_a), 32'h0);
        check("t2_wpcir",    32'(wpcir_a), 32'd0);
        next_cycle();
        id_use_rs = 1'b0;
        @(negedge clk);
        check("t2_fwda_nouse", 32'(fwda_b), 32'h0);
        next_cycle();
        id_use_rs = 1'b1; ex_wreg = 1'b0; mem_wreg = 1'b1; mem_destR = 5'd5; mem_m2reg = 1'b0;
        @(negedge clk);
        check("t2_fwda_mem_alu", 32'(fwda_b), 32'h2);
        $display("step 2: rs forwarding checked");

        // ---- 3: EX has priority over a MEM load on the same register
        next_cycle();
        clear_inputs();
        ex_wreg = 1'b1; ex_destR = 5'd7; mem_wreg = 1'b1; mem_destR = 5'd7; mem_m2reg = 1'b1;
        id_rt = 5'd7; id_use_rt = 1'b1;
        @(negedge clk);
        check("t3_fwdb_ex_prio", 32'(fwdb_a), 32'h1);
        next_cycle();
        ex_wreg = 1'b0;
        @(negedge clk);
        check("t3_fwdb_mem_load", 32'(fwdb_a), 32'h3);
        check("t3_fwda", 32'(fwda_a), 32'h0);
        $display("step 3: rt forwarding priority checked");

        // ---- 4: load-use stall (2 cycles on u_a, 3 cycles on u_b)
        next_cycle();
        do_reset();
        set_load_use();
        @(negedge clk);
        check("t4_a_wpcir_c0",  32'(wpcir_a), 32'd1);
        check("t4_a_bubble_c0", 32'(bubble_a), 32'd1);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        check("t4_a_wpcir_c1",  32'(wpcir_a), 32'd1);
        check("t4_a_bubble_c1", 32'(bubble_a), 32'd1);
        check("t4_a_stall_cnt_c1", 32'(stall_cnt_a), 32'(pc(16'd1)));
        next_cycle();
        @(negedge clk);
        check("t4_a_wpcir_c2",  32'(wpcir_a), 32'd0);
        check("t4_a_bubble_c2", 32'(bubble_a), 32'd0);
        check("t4_a_stall_cnt", 32'(stall_cnt_a), 32'(pc(16'd2)));
        check("t4_b_wpcir_c2",  32'(wpcir_b), 32'd1);
        next_cycle();
        @(negedge clk);
        check("t4_b_wpcir_c3",  32'(wpcir_b), 32'd0);
        check("t4_b_stall_cnt", 32'(stall_cnt_b), 32'(pc(16'd3)));
        $display("step 4: load-use stall length checked");

        // ---- 5: load-use and taken branch in the same cycle
        next_cycle();
        do_reset();
        set_load_use();
        id_branch = 1'b1;
        @(negedge clk);
        check("t5_a_wpcir_c0", 32'(wpcir_a), 32'd1);
        check("t5_a_flush_c0", 32'(flush_a), 32'd0);
        next_cycle();
        ex_wreg = 1'b0; ex_m2reg = 1'b0;        // load has left EX; branch still pending
        @(negedge clk);
        check("t5_a_wpcir_c1", 32'(wpcir_a), 32'd1);
        check("t5_a_flush_c1", 32'(flush_a), 32'd0);
        next_cycle();
        @(negedge clk);
        check("t5_a_flush_c2", 32'(flush_a), 32'd1);
        check("t5_a_wpcir_c2", 32'(wpcir_a), 32'd0);
        check("t5_b_wpcir_c2", 32'(wpcir_b), 32'd1);
        check("t5_b_flush_c2", 32'(flush_b), 32'd0);
        next_cycle();
        set_load_use();                          // new hazard while u_a is in FLUSH
        @(negedge clk);
        check("t5_a_flush_c3", 32'(flush_a), 32'd1);
        check("t5_a_wpcir_c3", 32'(wpcir_a), 32'd0);
        check("t5_b_wpcir_c3", 32'(wpcir_b), 32'd1);
        check("t5_b_flush_c3", 32'(flush_b), 32'd0);
        next_cycle();
        id_branch = 1'b0;
        @(negedge clk);
        check("t5_a_wpcir_deferred", 32'(wpcir_a), 32'd1);
        check("t5_a_flush_c4", 32'(flush_a), 32'd0);
        check("t5_a_flush_cnt", 32'(flush_cnt_a), 32'(pc(16'd2)));
        check("t5_a_stall_cnt", 32'(stall_cnt_a), 32'(pc(16'd2)));
        check("t5_b_stall_cnt", 32'(stall_cnt_b), 32'(pc(16'd4)));
        check("t5_b_flush_cnt", 32'(flush_cnt_b), 32'd0);
        $display("step 5: hazard and branch ordering checked");

        // ---- 6: register 0 never matches; counter saturation
        next_cycle();
        do_reset();
        ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_destR = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
        mem_wreg = 1'b1; mem_destR = 5'd0;
        @(negedge clk);
        check("t6_fwda_r0",  32'(fwda_a), 32'h0);
        check("t6_wpcir_r0", 32'(wpcir_a), 32'd0);
        check("t6_b_wpcir_r0", 32'(wpcir_b), 32'd0);
        next_cycle();
        clear_inputs();
        set_load_use();
        repeat (70000) @(posedge clk);
        @(negedge clk);
        check("t6_a_stall_sat", 32'(stall_cnt_a), 32'(pc(16'hFFFF)));
        check("t6_b_stall_sat", 32'(stall_cnt_b), 32'(pc(16'hFFFF)));
        check("t6_a_flush_cnt", 32'(flush_cnt_a), 32'd0);
        $display("step 6: reg0 and counter saturation checked");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
